// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//   UART receiver for 8N1 frames, with an optional parity bit. The serial line is
//   sampled at OVERSAMPLE ticks per bit. Each bit is decided by a 2-of-3 majority
//   vote taken at the middle of the bit. Framing and parity errors are flagged.
//   The divisor is programmed the same way as in the companion transmitter:
//   it is the number of clk cycles per oversample tick.
//
// Ports
//   clk        in   single clock
//   areset     in   synchronous, active-high reset
//   divisor    in   clk cycles per oversample tick; 0 is treated as 1
//   rx         in   asynchronous serial input, idle high
//   out_data   out  last received word, held until the next rx_done
//   rx_done    out  one-clk pulse: frame complete, out_data and error flags valid
//   frame_err  out  stop bit was sampled low (updated with rx_done)
//   parity_err out  parity mismatch (updated with rx_done; always 0 without parity)
//   busy       out  receiver is not idle
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on rx_s
// START  | checking the start bit at mid-bit; a high vote is a false start
// DATA   | shifting data bits in LSB first, one vote per bit
// PARITY | sampling the parity bit and computing the mismatch
// STOP   | sampling the stop bit; result and flags are published on the next clk
// BREAK  | stop bit was low; waits for rx_s high for one full tick
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_n_q, par_err_n_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;

  logic tick;
  logic decide;
  logic maj;
  logic start_edge;

  // The counter only runs outside IDLE, so ticks are always phase-aligned to the start edge.
  assign tick       = (state_q != S_IDLE) && (tick_cnt_q == (div_q - DIV_WIDTH'(1)));
  assign decide     = tick && (samp_cnt_q == SAMP_C);
  // The third vote is the live sample, so the bit is decided on the same clk as that tick.
  assign maj        = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
  assign start_edge = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_q        <= DIV_WIDTH'(1);
      tick_cnt_q   <= '0;
      samp_cnt_q   <= '0;
      vote_q       <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_err_n_q  <= 1'b0;
      out_data_q   <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      div_q        <= div_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      vote_q       <= vote_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_err_n_q  <= par_err_n_d;
      out_data_q   <= out_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    div_d        = div_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + DIV_WIDTH'(1);
    samp_cnt_d   = samp_cnt_q;
    vote_d       = vote_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_err_n_d  = par_err_n_q;
    out_data_d   = out_data_q;
    rx_done_d    = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    if (tick) begin
      samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SW'(1);
      if (samp_cnt_q == SAMP_A) vote_d[0] = rx_s_q;
      if (samp_cnt_q == SAMP_B) vote_d[1] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        if (start_edge) begin
          state_d     = S_START;
          div_d       = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
          bit_cnt_d   = '0;
          par_err_n_d = 1'b0;
        end
      end
      S_START: begin
        if (decide) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shreg_d   = {maj, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BITS_LAST) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_err_n_d = (^shreg_q) ^ maj ^ PAR_ODD;
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          rx_done_d    = 1'b1;
          out_data_d   = shreg_q;
          frame_err_d  = ~maj;
          parity_err_d = PAR_EN & par_err_n_q;
          // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
          state_d      = maj ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // Any low sample restarts the one-tick high qualification window.
        if (!rx_s_q) tick_cnt_d = '0;
        else if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    out_data   = out_data_q;
    rx_done    = rx_done_q;
    frame_err  = frame_err_q;
    parity_err = parity_err_q;
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

  logic        clk = 1'b0;
  logic        areset;
  logic [15:0] divisor;
  logic        rx_a, rx_b;
  logic [7:0]  data_a, data_b;
  logic        done_a, done_b, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16),
                       .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .areset(areset), .divisor(divisor), .rx(rx_a),
    .out_data(data_a), .rx_done(done_a), .frame_err(fe_a),
    .parity_err(pe_a), .busy(busy_a));

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16),
                       .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .areset(areset), .divisor(divisor), .rx(rx_b),
    .out_data(data_b), .rx_done(done_b), .frame_err(fe_b),
    .parity_err(pe_b), .busy(busy_b));

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Received-frame logs {parity_err, frame_err, data} and rx_done width monitor.
  logic [9:0] log_a[$];
  logic [9:0] log_b[$];
  int   wide_a = 0, wide_b = 0;
  logic prev_done_a = 1'b0, prev_done_b = 1'b0;

  always @(negedge clk) begin
    if (done_a) log_a.push_back({pe_a, fe_a, data_a});
    if (done_b) log_b.push_back({pe_b, fe_b, data_b});
    if (done_a && prev_done_a) wide_a++;
    if (done_b && prev_done_b) wide_b++;
    prev_done_a = done_a;
    prev_done_b = done_b;
  end

  function automatic int eff_div();
    return (divisor == 16'd0) ? 1 : int'(divisor);
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // A glitch inverts the line for exactly one tick period near mid-bit.
  task automatic drive_bit(input int which, input logic v, input logic glitch);
    int d;
    d = eff_div();
    set_line(which, v);
    if (glitch) begin
      hold(8 * d);
      set_line(which, ~v);
      hold(d);
      set_line(which, v);
      hold(7 * d);
    end else begin
      hold(16 * d);
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic use_par,
                            input logic par_bit, input logic stop_bit, input int glitch_bit);
    drive_bit(which, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i], i == glitch_bit);
    if (use_par) drive_bit(which, par_bit, 1'b0);
    drive_bit(which, stop_bit, 1'b0);
  endtask

  task automatic expect_frame(input int which, input string tag, input logic [7:0] data,
                              input logic fe, input logic pe);
    logic [9:0] e;
    int n;
    n = (which == 0) ? log_a.size() : log_b.size();
    check_eq({tag, "_avail"}, 32'(n != 0), 32'd1);
    if (n != 0) begin
      if (which == 0) e = log_a.pop_front();
      else            e = log_b.pop_front();
      check_eq({tag, "_data"}, 32'(e[7:0]), 32'(data));
      check_eq({tag, "_fe"}, 32'(e[8]), 32'(fe));
      check_eq({tag, "_pe"}, 32'(e[9]), 32'(pe));
    end
  endtask

  logic [7:0] rnd[10];

  initial begin
    int bc;
    areset  = 1'b1;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    divisor = 16'd4;
    hold(3);
    check_eq("rst_data", 32'(data_a), 32'h0);
    check_eq("rst_done", 32'(done_a), 32'h0);
    check_eq("rst_fe",   32'(fe_a),   32'h0);
    check_eq("rst_pe",   32'(pe_a),   32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    areset = 1'b0;
    hold(5);
    bc = 16 * eff_div();

    // T1: single good frame
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    hold(bc);
    expect_frame(0, "t1", 8'hA5, 1'b0, 1'b0);
    check_eq("t1_single", 32'(log_a.size()), 32'd0);
    check_eq("t1_idle", 32'(busy_a), 32'd0);

    // T2: low shorter than half a bit is a false start
    set_line(0, 1'b0);
    hold(12);
    check_eq("t2_busy", 32'(busy_a), 32'd1);
    hold(12);
    set_line(0, 1'b1);
    hold(2 * bc);
    check_eq("t2_nodone", 32'(log_a.size()), 32'd0);
    check_eq("t2_idle", 32'(busy_a), 32'd0);

    // T3: low stop bit, line held low with a short high blip, then recovery
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
    hold(bc);
    check_eq("t3_break_busy", 32'(busy_a), 32'd1);
    set_line(0, 1'b1);
    hold(2);
    set_line(0, 1'b0);
    hold(bc);
    set_line(0, 1'b1);
    hold(2 * bc);
    expect_frame(0, "t3", 8'h5A, 1'b1, 1'b0);
    check_eq("t3_no_extra", 32'(log_a.size()), 32'd0);
    check_eq("t3_fe_held", 32'(fe_a), 32'd1);
    check_eq("t3_idle", 32'(busy_a), 32'd0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    hold(bc);
    expect_frame(0, "t3b", 8'h11, 1'b0, 1'b0);
    check_eq("t3b_fe_level", 32'(fe_a), 32'd0);

    // T4: back-to-back frames with no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
    hold(bc);
    expect_frame(0, "t4a", 8'h00, 1'b0, 1'b0);
    expect_frame(0, "t4b", 8'hFF, 1'b0, 1'b0);
    expect_frame(0, "t4c", 8'h81, 1'b0, 1'b0);
    check_eq("t4_count", 32'(log_a.size()), 32'd0);

    // T5: reset during data bit 3 of 0xC3
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    set_line(0, 1'b0);
    hold(bc / 2);
    check_eq("t5_busy_pre", 32'(busy_a), 32'd1);
    areset = 1'b1;
    hold(1);
    check_eq("t5_data", 32'(data_a), 32'h0);
    check_eq("t5_busy", 32'(busy_a), 32'd0);
    check_eq("t5_done", 32'(done_a), 32'd0);
    check_eq("t5_fe",   32'(fe_a),   32'd0);
    areset = 1'b0;
    set_line(0, 1'b1);
    hold(3 * bc);
    check_eq("t5_nodone", 32'(log_a.size()), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
    hold(bc);
    expect_frame(0, "t5b", 8'h3C, 1'b0, 1'b0);

    // Divisor of zero behaves as one
    divisor = 16'd0;
    send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1, -1);
    hold(16);
    expect_frame(0, "div0", 8'h96, 1'b0, 1'b0);
    divisor = 16'd4;

    // One-tick glitches inside a bit must not flip it
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 2);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 1);
    hold(bc);
    expect_frame(0, "glitch1", 8'h55, 1'b0, 1'b0);
    expect_frame(0, "glitch0", 8'h55, 1'b0, 1'b0);

    // T6: even parity instance
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
    hold(bc);
    expect_frame(1, "t6_bad", 8'h07, 1'b0, 1'b1);
    check_eq("t6_pe_held", 32'(pe_b), 32'd1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    hold(bc);
    expect_frame(1, "t6_good", 8'h07, 1'b0, 1'b0);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
    hold(bc);
    expect_frame(1, "t6_even", 8'h03, 1'b0, 1'b0);

    // T7: ten random bytes at another divisor
    divisor = 16'd3;
    bc = 16 * eff_div();
    for (int i = 0; i < 10; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      send_frame(0, rnd[i], 1'b0, 1'b0, 1'b1, -1);
    end
    hold(bc);
    for (int i = 0; i < 10; i++) expect_frame(0, $sformatf("t7_%0d", i), rnd[i], 1'b0, 1'b0);

    check_eq("end_log_a", 32'(log_a.size()), 32'd0);
    check_eq("end_log_b", 32'(log_b.size()), 32'd0);
    check_eq("done_width_a", 32'(wide_a), 32'd0);
    check_eq("done_width_b", 32'(wide_b), 32'd0);
    check_eq("end_busy", 32'(busy_a | busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
